// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte layout for the SPI register responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 32;

    // Command byte: [7:3] register address, [1] direction, [2] and [0] ignored.
    localparam int   CMD_ADDR_MSB = 7;
    localparam int   CMD_ADDR_LSB = 3;
    localparam int   CMD_DIR_BIT  = 1;
    localparam logic DIR_WRITE    = 1'b1;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [DATA_W-1:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-bit pin synchronizer with registered rising/falling edge strobes.
module spi_pin_sync #(
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] prev;

    assign dout = chain[STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= INIT;
            prev <= INIT;
            rise <= '0;
            fall <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
            rise <= chain[STAGES-1] & ~prev;
            fall <= ~chain[STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target exposing a 32 x 8 register file, with a fabric side port
// for preloading and observing registers.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int STATUS_ADDR = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] STATUS_A = STATUS_ADDR[ADDR_W-1:0];

    logic [2:0] pin_sync, pin_rise, pin_fall;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall, ss_sync, mosi_sync;
    logic       unused_pin_bits;

    // SS_n resets high so reset never fabricates a select edge.
    spi_pin_sync #(
        .WIDTH (3),
        .STAGES(SYNC_STAGES),
        .INIT  (3'b010)
    ) u_pin_sync (
        .clk (clk),
        .rst (rst),
        .din ({spi_sclk, spi_ss_n, spi_mosi}),
        .dout(pin_sync),
        .rise(pin_rise),
        .fall(pin_fall)
    );

    assign sclk_rise       = pin_rise[2];
    assign sclk_fall       = pin_fall[2];
    assign ss_rise         = pin_rise[1];
    assign ss_fall         = pin_fall[1];
    assign ss_sync         = pin_sync[1];
    assign mosi_sync       = pin_sync[0];
    assign unused_pin_bits = ^{pin_sync[2], pin_rise[0], pin_fall[0]};

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] rx, tx;
    logic [ADDR_W-1:0] addr;
    logic              dir;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [DATA_W-1:0] rx_next;
    logic              byte_done, spi_we;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rx_next   = {rx[DATA_W-2:0], mosi_sync};
        byte_done = 1'b0;
        if (state != IDLE && !ss_rise && sclk_rise && bit_cnt == 3'd7)
            byte_done = 1'b1;
        spi_we = byte_done && state == DATA && dir == DIR_WRITE;
    end

    assign spi_miso    = tx[DATA_W-1];
    assign spi_miso_oe = ~ss_sync;
    assign busy        = state != IDLE;
    assign host_rdata  = regs[host_addr];

    // NOTE: the register file is reset because software expects a known zero
    // image; the SPI write is placed last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (spi_we)  regs[addr]      <= rx_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            addr     <= '0;
            dir      <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_valid <= 1'b0;
            if (ss_rise) begin
                state <= IDLE;
            end else if (ss_fall && state == IDLE) begin
                state   <= CMD;
                bit_cnt <= '0;
                tx      <= regs[STATUS_A];
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    rx      <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done && state == CMD) begin
                        state <= DATA;
                        addr  <= cmd_addr(rx_next);
                        dir   <= rx_next[CMD_DIR_BIT];
                        if (rx_next[CMD_DIR_BIT] != DIR_WRITE) begin
                            tx       <= regs[cmd_addr(rx_next)];
                            rd_valid <= 1'b1;
                        end
                    end else if (byte_done) begin
                        if (dir == DIR_WRITE) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr;
                            wr_data  <= rx_next;
                        end else begin
                            tx       <= regs[addr];
                            rd_valid <= 1'b1;
                        end
                    end
                end else if (sclk_fall && bit_cnt != 3'd0) begin
                    // Hold the freshly loaded byte across the boundary falling edge.
                    tx <= {tx[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench: directed scenarios plus random transactions scored
// against a transaction-level register model.
module tb_spi_reg_responder;

    localparam int SYNC     = 2;
    localparam int STATUS   = 25;
    localparam int HALF     = 5;
    localparam int SCK_CLKS = 8;
    localparam int LAT      = (SYNC + 2) * 2 * HALF;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic       host_we;
    logic [4:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       wr_valid, rd_valid, busy;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    spi_reg_responder #(
        .STATUS_ADDR(STATUS),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_ss_n   (spi_ss_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .busy       (busy)
    );

    always #HALF clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling clock edge.
    int         wr_cnt = 0, rd_cnt = 0;
    time        wr_t = 0, rd_t = 0;
    logic [4:0] wr_a = '0;
    logic [7:0] wr_d = '0;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            wr_t = $time;
            wr_a = wr_addr;
            wr_d = wr_data;
        end
        if (rd_valid) begin
            rd_cnt++;
            rd_t = $time;
        end
    end

    logic [7:0] ref_regs [32];
    logic [7:0] txq [$];
    time        t_rise8;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick(1);
        host_we    = 1'b0;
        ref_regs[a] = d;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [7:0] exp);
        host_addr = a;
        tick(1);
        check(tag, host_rdata, exp);
    endtask

    // One mode-0 byte (or the first nbits of it); optionally fires a host
    // write in the exact cycle the 8th-edge SPI write lands.
    task automatic spi_byte(input logic [7:0] out_b, input int nbits, input bit collide,
                            input logic [4:0] ca, input logic [7:0] cd, output logic [7:0] in_b);
        in_b = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = out_b[i];
            tick(SCK_CLKS);
            in_b[i]  = spi_miso;
            spi_sclk = 1'b1;
            if (i == 0) t_rise8 = $time;
            if (i == 0 && collide) begin
                tick(SYNC + 1);
                host_addr  = ca;
                host_wdata = cd;
                host_we    = 1'b1;
                tick(1);
                host_we    = 1'b0;
                tick(SCK_CLKS - SYNC - 2);
            end else begin
                tick(SCK_CLKS);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_start();
        spi_ss_n = 1'b0;
        tick(SCK_CLKS);
    endtask

    task automatic spi_stop();
        tick(SCK_CLKS);
        spi_ss_n = 1'b1;
        tick(SCK_CLKS);
    endtask

    // Drives txq as one transaction; expectations come from ref_regs.
    task automatic run_txn(input string tag);
        logic [7:0] got;
        logic [4:0] a;
        logic       w;
        logic [7:0] exp_first;
        int         wr0, rd0, exp_wr, exp_rd;
        wr0       = wr_cnt;
        rd0       = rd_cnt;
        exp_wr    = 0;
        exp_rd    = 0;
        a         = txq[0][7:3];
        w         = txq[0][1];
        exp_first = ref_regs[STATUS];
        spi_start();
        check({tag, " busy_active"}, busy, 1);
        check({tag, " oe_active"}, spi_miso_oe, 1);
        for (int i = 0; i < txq.size(); i++) begin
            spi_byte(txq[i], 8, 1'b0, 5'd0, 8'd0, got);
            if (i == 0) check({tag, " status_byte"}, got, exp_first);
            else if (!w) check({tag, " read_byte"}, got, ref_regs[a]);
            if (!w) begin
                exp_rd++;
                check({tag, " rd_latency"}, rd_t - t_rise8, LAT);
            end else if (i > 0) begin
                ref_regs[a] = txq[i];
                exp_wr++;
                check({tag, " wr_latency"}, wr_t - t_rise8, LAT);
                check({tag, " wr_addr"}, wr_a, a);
                check({tag, " wr_data"}, wr_d, txq[i]);
            end
        end
        spi_stop();
        check({tag, " wr_count"}, wr_cnt - wr0, exp_wr);
        check({tag, " rd_count"}, rd_cnt - rd0, exp_rd);
        check({tag, " busy_idle"}, busy, 0);
        check({tag, " oe_idle"}, spi_miso_oe, 0);
        peek({tag, " host_rdata"}, a, ref_regs[a]);
    endtask

    initial begin
        logic [7:0] got;
        int         wr0;

        rst        = 1'b1;
        spi_sclk   = 1'b0;
        spi_ss_n   = 1'b1;
        spi_mosi   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        tick(3);
        rst = 1'b0;
        tick(5);

        check("reset miso", spi_miso, 0);
        check("reset oe", spi_miso_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr_valid", wr_valid, 0);
        check("reset rd_valid", rd_valid, 0);
        peek("reset reg25", 5'd25, 8'h00);

        // Write 0x5C to register 21.
        txq = {8'hAA, 8'h5C};
        run_txn("write21");
        peek("write21 const", 5'd21, 8'h5C);

        // Preloaded status and data registers, single read.
        host_write(5'd25, 8'h81);
        host_write(5'd9, 8'h3E);
        txq = {8'h48, 8'h00};
        run_txn("read9");

        // Burst read repeats the same register.
        txq = {8'h48, 8'h00, 8'h00, 8'h00};
        run_txn("burst9");

        // Abort after 5 bits of the data byte.
        wr0 = wr_cnt;
        spi_start();
        spi_byte(8'hAA, 8, 1'b0, 5'd0, 8'd0, got);
        spi_byte(8'h77, 5, 1'b0, 5'd0, 8'd0, got);
        check("abort busy_before", busy, 1);
        tick(SCK_CLKS);
        spi_ss_n = 1'b1;
        tick(SCK_CLKS);
        check("abort no_wr", wr_cnt - wr0, 0);
        check("abort busy_after", busy, 0);
        peek("abort reg21", 5'd21, ref_regs[21]);
        txq = {8'hA8, 8'h00};
        run_txn("after_abort_read");
        txq = {8'h4A, 8'h9D};
        run_txn("after_abort_write");

        // Same-address collision: SPI write wins.
        wr0 = wr_cnt;
        spi_start();
        spi_byte(8'hAA, 8, 1'b0, 5'd0, 8'd0, got);
        spi_byte(8'h22, 8, 1'b1, 5'd21, 8'h11, got);
        spi_stop();
        check("collide wr_count", wr_cnt - wr0, 1);
        peek("collide same", 5'd21, 8'h22);
        ref_regs[21] = 8'h22;

        // Different-address collision: both land.
        spi_start();
        spi_byte(8'hAA, 8, 1'b0, 5'd0, 8'd0, got);
        spi_byte(8'h33, 8, 1'b1, 5'd5, 8'h44, got);
        spi_stop();
        peek("collide spi_side", 5'd21, 8'h33);
        peek("collide host_side", 5'd5, 8'h44);
        ref_regs[21] = 8'h33;
        ref_regs[5]  = 8'h44;

        // Random transactions against the model.
        for (int n = 0; n < 10; n++) begin
            int nd;
            if ($urandom_range(0, 1) == 1)
                host_write(5'($urandom_range(0, 31)), 8'($urandom));
            if ($urandom_range(0, 3) == 0)
                host_write(5'(STATUS), 8'($urandom));
            txq = {};
            txq.push_back(8'($urandom));
            nd = $urandom_range(1, 3);
            for (int k = 0; k < nd; k++) txq.push_back(8'($urandom));
            run_txn($sformatf("rand%0d", n));
        end

        // Reset in the middle of the command byte.
        spi_start();
        spi_byte(8'hAA, 3, 1'b0, 5'd0, 8'd0, got);
        rst = 1'b1;
        tick(1);
        check("midrst miso", spi_miso, 0);
        check("midrst oe", spi_miso_oe, 0);
        check("midrst busy", busy, 0);
        check("midrst wr_valid", wr_valid, 0);
        check("midrst rd_valid", rd_valid, 0);
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(5);
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        for (int i = 0; i < 32; i++) peek($sformatf("midrst reg%0d", i), 5'(i), 8'h00);
        txq = {8'hAA, 8'h66};
        run_txn("post_reset_write");
        txq = {8'hA8, 8'h00};
        run_txn("post_reset_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
